// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU VRAM responder: mirroring modes, address map,
// slot FSM states and the address-decode helpers.
package ppu_pkg;

  localparam logic [1:0] MIR_HORIZ    = 2'd0;
  localparam logic [1:0] MIR_VERT     = 2'd1;
  localparam logic [1:0] MIR_SINGLE_A = 2'd2;
  localparam logic [1:0] MIR_SINGLE_B = 2'd3;

  localparam logic [13:0] NT_BASE  = 14'h2000;
  localparam logic [13:0] PAL_BASE = 14'h3F00;

  typedef enum logic [1:0] {
    REG_CHR = 2'd0,
    REG_NT  = 2'd1,
    REG_PAL = 2'd2
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_ISSUE = 2'd2
  } slot_st_t;

  function automatic region_t addr_region(input logic [13:0] a);
    region_t r;
    if (a < NT_BASE)
      r = REG_CHR;
    else if (a < PAL_BASE)
      r = REG_NT;
    else
      r = REG_PAL;
    return r;
  endfunction

  // $3000-$3EFF folds onto $2000-$2EFF because only a[11:0] reaches the mirroring logic.
  function automatic logic [10:0] nt_addr(input logic [13:0] a, input logic [1:0] mirror);
    logic [10:0] r;
    case (mirror)
      MIR_HORIZ:    r = {a[11], a[9:0]};
      MIR_VERT:     r = {a[10], a[9:0]};
      MIR_SINGLE_A: r = {1'b0, a[9:0]};
      default:      r = {1'b1, a[9:0]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ppu_pal_ram.sv
// 32-entry palette register file; sprite backdrop entries alias the background ones.
module ppu_pal_ram
  import ppu_pkg::*;
#(
  parameter int PAL_W = 6
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             we_in,
  input  logic [4:0]       wa_in,
  input  logic [PAL_W-1:0] wd_in,
  input  logic [4:0]       ra_in,
  output logic [PAL_W-1:0] rd_out
);

  logic [PAL_W-1:0] mem [32];

  function automatic logic [4:0] pal_idx(input logic [4:0] a);
    return (a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
  endfunction

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < 32; i++)
        mem[i] <= '0;
    end else if (we_in) begin
      mem[pal_idx(wa_in)] <= wd_in;
    end
  end

  assign rd_out = mem[pal_idx(ra_in)];

endmodule

// File: rtl/ppu_vram_resp.sv
// PPU VRAM responder: arbitrates render fetches and the CPU $2007 slot onto CIRAM,
// CHR and palette RAM, and implements the $2007 read buffer.
module ppu_vram_resp
  import ppu_pkg::*;
#(
  parameter int PAL_W = 6
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [1:0]  mirror_in,
  input  logic [13:0] rd_a_in,
  input  logic        rd_en_in,
  output logic [7:0]  rd_d_out,
  input  logic [13:0] ri_a_in,
  input  logic        ri_rd_in,
  input  logic        ri_wr_in,
  input  logic [7:0]  ri_d_in,
  output logic [7:0]  ri_d_out,
  output logic        ri_busy_out,
  output logic [10:0] ciram_a_out,
  output logic        ciram_we_out,
  output logic [7:0]  ciram_d_out,
  input  logic [7:0]  ciram_d_in,
  output logic [12:0] chr_a_out,
  output logic        chr_we_out,
  output logic [7:0]  chr_d_out,
  input  logic [7:0]  chr_d_in
);

  slot_st_t         st;
  logic [13:0]      slot_a;
  logic [7:0]       slot_d;
  logic             slot_wr;
  logic             slot_load;

  logic             issue;
  logic             acc_act;
  logic [13:0]      acc_a;
  logic [13:0]      acc_shadow_a;
  region_t          acc_rgn;
  logic             pal_we;
  logic [PAL_W-1:0] pal_rd;

  logic             rd_vld_p1;
  logic             cpu_vld_p1;
  region_t          rgn_p1;
  logic [PAL_W-1:0] pal_p1;
  logic [7:0]       src_p1;
  logic [7:0]       rd_hold;
  logic [7:0]       rbuf;

  // ---- stage p0: one address onto the memories per cycle, CPU slot only in ISSUE
  assign issue        = (st == ST_ISSUE);
  assign acc_a        = issue ? slot_a : rd_a_in;
  assign acc_act      = issue | rd_en_in;
  assign acc_rgn      = addr_region(acc_a);
  assign acc_shadow_a = acc_a - 14'h1000;
  assign slot_load    = (st == ST_IDLE) && (ri_rd_in || ri_wr_in);

  always_comb begin
    ciram_a_out  = '0;
    ciram_we_out = 1'b0;
    ciram_d_out  = '0;
    chr_a_out    = '0;
    chr_we_out   = 1'b0;
    chr_d_out    = '0;
    pal_we       = 1'b0;
    if (acc_act) begin
      case (acc_rgn)
        REG_CHR: begin
          chr_a_out = acc_a[12:0];
          if (issue && slot_wr) begin
            chr_we_out = 1'b1;
            chr_d_out  = slot_d;
          end
        end
        REG_NT: begin
          ciram_a_out = nt_addr(acc_a, mirror_in);
          if (issue && slot_wr) begin
            ciram_we_out = 1'b1;
            ciram_d_out  = slot_d;
          end
        end
        REG_PAL: begin
          if (issue && slot_wr)
            pal_we = 1'b1;
          else if (issue)
            ciram_a_out = nt_addr(acc_shadow_a, mirror_in);
        end
        default: ;
      endcase
    end
  end

  ppu_pal_ram #(.PAL_W(PAL_W)) u_pal (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .we_in    (pal_we),
    .wa_in    (slot_a[4:0]),
    .wd_in    (slot_d[PAL_W-1:0]),
    .ra_in    (acc_a[4:0]),
    .rd_out   (pal_rd)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      st          <= ST_IDLE;
      ri_busy_out <= 1'b0;
      rd_vld_p1   <= 1'b0;
      cpu_vld_p1  <= 1'b0;
    end else begin
      rd_vld_p1  <= rd_en_in && !issue;
      cpu_vld_p1 <= issue && !slot_wr;
      case (st)
        ST_IDLE: begin
          if (slot_load) begin
            st          <= ST_PEND;
            ri_busy_out <= 1'b1;
          end
        end
        ST_PEND: begin
          if (!rd_en_in)
            st <= ST_ISSUE;
        end
        default: begin
          st          <= ST_IDLE;
          ri_busy_out <= 1'b0;
        end
      endcase
    end
  end

  // Requests arriving while busy never load the slot; write wins when both strobes fire.
  always_ff @(posedge clk_in) begin
    if (slot_load) begin
      slot_a  <= ri_a_in;
      slot_d  <= ri_d_in;
      slot_wr <= ri_wr_in;
    end
    rgn_p1 <= acc_rgn;
    pal_p1 <= pal_rd;
  end

  // ---- stage p1: synchronous memory data returns, select source and update buffers
  always_comb begin
    case (rgn_p1)
      REG_CHR: src_p1 = chr_d_in;
      REG_NT:  src_p1 = ciram_d_in;
      default: src_p1 = 8'(pal_p1);
    endcase
  end

  assign rd_d_out = rd_vld_p1 ? src_p1 : rd_hold;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_hold  <= '0;
      ri_d_out <= '0;
      rbuf     <= '0;
    end else begin
      if (rd_vld_p1)
        rd_hold <= src_p1;
      if (cpu_vld_p1) begin
        // Palette reads bypass the buffer; the buffer picks up the nametable byte underneath.
        if (rgn_p1 == REG_PAL) begin
          ri_d_out <= 8'(pal_p1);
          rbuf     <= ciram_d_in;
        end else begin
          ri_d_out <= rbuf;
          rbuf     <= src_p1;
        end
      end
    end
  end

endmodule
